// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write scheduler and its arbiter.
package rf_sched_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares one register-file write port between NUM_REQ writeback requesters (round-robin),
// with a clear walk that zeroes every register; rf_* outputs are registered, 1-cycle latency.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_addr,
  output logic [DATA_W-1:0]           rf_wd
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  state_e              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [NUM_REQ-1:0]  w_arb_grant, w_grant;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   w_gnt_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_arb_grant)
  );

  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // clear_start outranks any pending request in IDLE
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = '0;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_grant = w_arb_grant;
          if (|w_arb_grant) begin
            w_rr_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + PTR_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == LAST_REG) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = rst ? '0 : w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_clr_cnt  <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wd      <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_clr_cnt  <= (r_state == ST_CLEAR) ? r_clr_cnt + ADDR_W'(1) : '0;
      clear_busy <= (w_state_nxt == ST_CLEAR);
      clear_done <= (r_state == ST_DONE);
      if (r_state == ST_CLEAR) begin
        rf_we   <= 1'b1;
        rf_addr <= r_clr_cnt;
        rf_wd   <= '0;
      end else if (|w_grant) begin
        // $zero handshakes normally but never reaches the register file
        rf_we   <= (w_gnt_addr != ZERO_ADDR);
        rf_addr <= w_gnt_addr;
        rf_wd   <= w_gnt_data;
      end else begin
        rf_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler (NUM_REQ=2, NUM_REGS=32).
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  int vectors = 0;
  int errs    = 0;

  rf_write_scheduler #(
    .NUM_REQ  (2),
    .ADDR_W   (5),
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wd       (rf_wd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  initial begin
    int writes;
    int dones;
    int done_cyc;
    rst = 1'b1;
    clear_start = 1'b0;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick;
    tick;
    #1;
    chk("reset_ready", 64'(req_ready), 64'(2'b00));
    chk("reset_rf", {rf_we, rf_addr, rf_wd}, 64'h0);
    chk("reset_clear", {clear_busy, clear_done}, 64'h0);

    // single requester
    rst = 1'b0;
    set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1 chk("single_ready", 64'(req_ready), 64'(2'b01));
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 chk("single_write", {rf_we, rf_addr, rf_wd}, {1'b1, 5'd5, 32'hDEADBEEF});
    chk("single_idle_ready", 64'(req_ready), 64'(2'b00));
    tick;
    chk("single_we_drop", 64'(rf_we), 64'(1'b0));

    // re-reset to put rr_ptr at 0, then contention
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_req(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
    for (int k = 0; k < 4; k++) begin
      #1 chk("contend_ready", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      tick;
      chk("contend_write", {rf_we, rf_addr, rf_wd},
          (k % 2 == 0) ? {1'b1, 5'd3, 32'h11} : {1'b1, 5'd4, 32'h22});
    end
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // address-0 write: handshake completes, no write enable
    set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'h0000FFFF);
    #1 chk("zero_ready", 64'(req_ready), 64'(2'b10));
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("zero_write", {rf_we, rf_addr, rf_wd}, {1'b0, 5'd0, 32'h0000FFFF});

    // full clear with r0 waiting
    set_req(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
    clear_start = 1'b1;
    #1 chk("clr_c0_ready", 64'(req_ready), 64'(2'b00));
    tick;
    clear_start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      chk("clr_ready", 64'(req_ready), 64'(2'b00));
      chk("clr_busy_done", {clear_busy, clear_done}, {(c <= 32), 1'b0});
      if (c == 1) chk("clr_first_idle", 64'(rf_we), 64'(1'b0));
      else chk("clr_write", {rf_we, rf_addr, rf_wd}, {1'b1, 5'(c - 2), 32'h0});
      tick;
    end
    chk("clr_done_pulse", {clear_busy, clear_done, rf_we}, {1'b0, 1'b1, 1'b0});
    chk("clr_resume_ready", 64'(req_ready), 64'(2'b01));
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("clr_served", {rf_we, rf_addr, rf_wd}, {1'b1, 5'd7, 32'h77});
    chk("clr_done_once", 64'(clear_done), 64'(1'b0));

    // reset in the middle of a clear walk (rr_ptr is 1 beforehand)
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    for (int c = 1; c < 12; c++) tick;
    chk("rstclr_at10", {rf_we, rf_addr}, {1'b1, 5'd10});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstclr_after", {rf_we, clear_busy, clear_done}, 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rstclr_no_done", {rf_we, clear_busy, clear_done}, 64'h0);
    end
    set_req(2'b11, 5'd8, 32'h88, 5'd9, 32'h99);
    #1 chk("rstclr_ptr0", 64'(req_ready), 64'(2'b01));
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("rstclr_served", {rf_we, rf_addr, rf_wd}, {1'b1, 5'd8, 32'h88});
    tick;

    // second clear_start during the walk is ignored
    writes = 0;
    dones = 0;
    done_cyc = -1;
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      clear_start = (c == 17);
      if (c == 17) chk("retrig_addr15", {rf_we, rf_addr}, {1'b1, 5'd15});
      if (rf_we) writes++;
      if (clear_done) begin
        dones++;
        done_cyc = c;
      end
      tick;
    end
    clear_start = 1'b0;
    chk("retrig_writes", 64'(writes), 64'd32);
    chk("retrig_dones", 64'(dones), 64'd1);
    chk("retrig_done_cycle", 64'(done_cyc), 64'd34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between NUM_REQ writeback requesters, e.g. ALU result and memory load.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Contains a clear sequencer that zeroes every register, one per cycle, on command.
- Sits between the writeback stage and the register file. Its registered outputs drive the register file's write port directly.

Parameters:
- NUM_REQ, 2, number of write requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers walked by the clear sequence (must be ≤ 2^ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both 1.
- clear_start  in  1  single-cycle command to zero all registers.
- clear_busy  out  1  high while the clear walk is in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- rf_we  out  1  register-file write enable (registered).
- rf_addr  out  ADDR_W  register-file write address (registered).
- rf_wd  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset: state=IDLE, rr_ptr=0, rf_we=0, rf_addr=0, rf_wd=0, req_ready=0, clear_busy=0, clear_done=0, clear counter=0.
- States:
  - IDLE: arbitrate requesters.
  - CLEAR: walk registers, one zero write per cycle.
  - DONE: one cycle; clear_done=1; then return to IDLE.
- IDLE, no clear_start:
  - req_ready is combinational: one-hot on the first valid requester, searching from rr_ptr upward with wrap-around.
  - All ready bits are 0 when no requester is valid.
  - Never more than one ready bit high.
  - On a grant to requester g, rr_ptr ← (g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Write latency: exactly 1 cycle. The edge that accepts requester g loads rf_we=1, rf_addr=req_addr[g], rf_wd=req_data[g]. In any cycle without a grant, rf_we←0.
- Address 0 ($zero) writes from requesters: the handshake completes (ready=1) but rf_we stays 0. rf_addr and rf_wd still update.
- clear_start in IDLE:
  - Has priority over requests; all req_ready=0 in that cycle.
  - Next state is CLEAR, counter←0, clear_busy←1.
- CLEAR:
  - Every cycle: rf_we=1, rf_addr=counter, rf_wd=0, registered one cycle behind the counter.
  - Counter runs 0..NUM_REGS-1, producing NUM_REGS consecutive writes. Address 0 is included.
  - req_ready=0 throughout. Requesters hold valid/addr/data and are served later.
  - clear_start is ignored. rr_ptr is unchanged.
- DONE:
  - rf_we=0, clear_busy=0, clear_done=1 for exactly one cycle; then IDLE.
  - Arbitration resumes in the cycle after DONE.
- clear_start to clear_done: NUM_REGS+2 cycles. With NUM_REGS=32, clear_done is high in the 34th cycle after the clear_start cycle.
- A request arriving in the same cycle as clear_start is not granted in that cycle.
- rst asserted mid-CLEAR or mid-grant: all state returns to reset values on that edge. A partial clear is abandoned with no clear_done.
- req_data/req_addr of non-granted requesters are don't-care.

Decomposition:
- Shared package rf_sched_pkg holds:
  - state encoding (ST_IDLE, ST_CLEAR, ST_DONE);
  - ZERO_REG address constant (0);
  - default widths ADDR_W=5, DATA_W=32.
- One sub-module: rr_arbiter (NUM_REQ): inputs req, ptr; output grant one-hot. Purely combinational, reusable by other shared-port controllers.
- The FSM, counter and output registers stay in rf_write_scheduler.

Test Plan:
- Single requester: after reset, req_valid=01, addr=5, data=0xDEADBEEF → ready=01 that cycle; next cycle rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
- Contention: both valid continuously, r0 addr=3/data=0x11, r1 addr=4/data=0x22, rr_ptr=0 → grants alternate 01,10,01,10; rf_addr sequence 3,4,3,4; ready never 11.
- Address 0 write: r1 valid, addr=0, data=0xFFFF → ready=10, rf_we stays 0.
- Clear: clear_start pulse with r0 valid (addr=7) → ready=00 for 34 cycles; rf_we=1 with rf_addr=0..31 and rf_wd=0 on 32 consecutive cycles; clear_done pulses once; the next cycle grants r0 and rf_addr=7 appears one cycle later.
- Reset mid-clear: rst=1 when rf_addr=10 during CLEAR → next cycle rf_we=0, clear_busy=0, no clear_done; a subsequent request is served normally with rr_ptr=0.
- Clear re-trigger ignored: clear_start pulsed again at walk address 15 → still exactly 32 writes and a single clear_done.
